// File: rtl/note_grid_renderer.sv
// Initiator for the draw_block handshake: on frame_start, snapshots the note map and
// lane colours, then issues one block draw per grid cell in row-major order.
module note_grid_renderer #(
  parameter int unsigned NUM_LANES  = 4,
  parameter int unsigned NUM_ROWS   = 8,
  parameter logic [7:0]  X_ORIGIN   = 8'd40,
  parameter logic [7:0]  Y_ORIGIN   = 8'd16,
  parameter logic [7:0]  LANE_PITCH = 8'd8,
  parameter logic [7:0]  ROW_PITCH  = 8'd8,
  parameter logic [2:0]  BG_COLOR   = 3'b000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [NUM_LANES*NUM_ROWS-1:0] note_map,
  input  logic [3*NUM_LANES-1:0]        lane_colors,
  input  logic                          blk_done,
  output logic                          blk_go,
  output logic [7:0]                    blk_x,
  output logic [7:0]                    blk_y,
  output logic [2:0]                    blk_color,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned CELLS = NUM_LANES * NUM_ROWS;
  localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int unsigned IW = (CELLS > 1) ? $clog2(CELLS) : 1;

  typedef enum logic [2:0] {
    IDLE, LOAD, ISSUE, WAIT_LOW, WAIT_HIGH, NEXT, DONE
  } state_t;

  state_t                   state;
  logic [LW-1:0]            lane;
  logic [RW-1:0]            row;
  logic [CELLS-1:0]         map_snap;
  logic [3*NUM_LANES-1:0]   col_snap;

  logic [LW-1:0]            cell_lane;
  logic [RW-1:0]            cell_row;
  logic [CELLS-1:0]         map_src;
  logic [3*NUM_LANES-1:0]   col_src;
  logic [IW-1:0]            cell_idx;
  logic [2:0]               lane_col;
  logic [7:0]               cell_x;
  logic [7:0]               cell_y;
  logic [2:0]               cell_color;
  logic                     last_cell;

  assign blk_go    = (state == ISSUE) && blk_done;
  assign last_cell = (lane == LW'(NUM_LANES - 1)) && (row == RW'(NUM_ROWS - 1));

  // Outputs for the cell about to be drawn: cell 0 from the live inputs while loading
  // (they are captured on the same edge), otherwise the successor of lane/row from the snapshot.
  always_comb begin
    cell_lane = '0;
    cell_row  = '0;
    map_src   = map_snap;
    col_src   = col_snap;
    if (state == LOAD) begin
      map_src = note_map;
      col_src = lane_colors;
    end else if (lane == LW'(NUM_LANES - 1)) begin
      cell_row = row + 1'b1;
    end else begin
      cell_lane = lane + 1'b1;
      cell_row  = row;
    end
    cell_x   = X_ORIGIN + 8'(cell_lane) * LANE_PITCH;
    cell_y   = Y_ORIGIN + 8'(cell_row) * ROW_PITCH;
    cell_idx = IW'(32'(cell_row) * NUM_LANES + 32'(cell_lane));
    lane_col = BG_COLOR;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      if (cell_lane == LW'(l)) lane_col = col_src[3*l +: 3];
    end
    cell_color = map_src[cell_idx] ? lane_col : BG_COLOR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      lane       <= '0;
      row        <= '0;
      map_snap   <= '0;
      col_snap   <= '0;
      blk_x      <= '0;
      blk_y      <= '0;
      blk_color  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (frame_start) begin
          state <= LOAD;
          busy  <= 1'b1;
        end
        LOAD: begin
          map_snap  <= note_map;
          col_snap  <= lane_colors;
          lane      <= '0;
          row       <= '0;
          blk_x     <= cell_x;
          blk_y     <= cell_y;
          blk_color <= cell_color;
          state     <= ISSUE;
        end
        ISSUE:     if (blk_done)  state <= WAIT_LOW;
        WAIT_LOW:  if (!blk_done) state <= WAIT_HIGH;
        WAIT_HIGH: if (blk_done)  state <= NEXT;
        NEXT: begin
          if (last_cell) begin
            frame_done <= 1'b1;
            state      <= DONE;
          end else begin
            lane      <= cell_lane;
            row       <= cell_row;
            blk_x     <= cell_x;
            blk_y     <= cell_y;
            blk_color <= cell_color;
            state     <= ISSUE;
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_grid_renderer.sv
// Scoreboard bench for note_grid_renderer with a draw_block responder (done low 17 cycles).
module tb_note_grid_renderer;

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [31:0] note_map;
  logic [11:0] lane_colors;
  logic        blk_done;
  logic        blk_go, blk_go2;
  logic [7:0]  blk_x, blk_y, blk_x2, blk_y2;
  logic [2:0]  blk_color, blk_color2;
  logic        busy, busy2, frame_done, frame_done2;

  logic        mdone;
  int          mcnt;
  logic        hold_low;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          fd_count = 0;

  typedef struct {
    int x;
    int y;
    int color;
    int x2;
    int go_cyc;
  } cell_t;

  cell_t exp_q[$];
  int    fd_q[$];

  always #5 clock = ~clock;

  note_grid_renderer dut (
    .clock(clock), .reset(reset), .frame_start(frame_start), .note_map(note_map),
    .lane_colors(lane_colors), .blk_done(blk_done), .blk_go(blk_go), .blk_x(blk_x),
    .blk_y(blk_y), .blk_color(blk_color), .busy(busy), .frame_done(frame_done)
  );

  note_grid_renderer #(.X_ORIGIN(8'd250), .LANE_PITCH(8'd4)) dut2 (
    .clock(clock), .reset(reset), .frame_start(frame_start), .note_map(note_map),
    .lane_colors(lane_colors), .blk_done(blk_done), .blk_go(blk_go2), .blk_x(blk_x2),
    .blk_y(blk_y2), .blk_color(blk_color2), .busy(busy2), .frame_done(frame_done2)
  );

  assign blk_done = mdone & ~hold_low;

  always @(posedge clock) cyc <= cyc + 1;

  // draw_block responder
  always @(posedge clock) begin
    if (reset) begin
      mdone <= 1'b1;
      mcnt  <= 0;
    end else if (blk_go) begin
      mdone <= 1'b0;
      mcnt  <= 17;
    end else if (mcnt > 1) begin
      mcnt <= mcnt - 1;
    end else if (mcnt == 1) begin
      mcnt  <= 0;
      mdone <= 1'b1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor
  always @(negedge clock) begin
    cell_t e;
    int    t;
    if (blk_go) begin
      if (exp_q.size() == 0) begin
        check("unexpected_go", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("blk_x", int'(blk_x), e.x);
        check("blk_y", int'(blk_y), e.y);
        check("blk_color", int'(blk_color), e.color);
        check("dut2_go", int'(blk_go2), 1);
        check("dut2_x_wrap", int'(blk_x2), e.x2);
        check("dut2_y", int'(blk_y2), e.y);
        check("dut2_color", int'(blk_color2), e.color);
        if (e.go_cyc >= 0) check("go_cycle", cyc, e.go_cyc);
      end
    end
    if (frame_done) begin
      fd_count++;
      check("dut2_frame_done", int'(frame_done2), 1);
      check("busy_in_done", int'(busy), 1);
      if (fd_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        t = fd_q.pop_front();
        if (t >= 0) check("frame_done_cycle", cyc, t);
      end
    end
  end

  // Issue a one-cycle frame_start pulse and queue the expected draws; returns at the
  // negedge during which the DUT sits in LOAD.
  task automatic start_frame(input logic [31:0] m, input logic [11:0] c, input bit timed);
    int t0;
    note_map    = m;
    lane_colors = c;
    t0 = cyc + 1;
    for (int r = 0; r < 8; r++) begin
      for (int l = 0; l < 4; l++) begin
        cell_t e;
        e.x      = (40 + 8 * l) % 256;
        e.y      = 16 + 8 * r;
        e.color  = m[r*4+l] ? int'(c[3*l +: 3]) : 0;
        e.x2     = (250 + 4 * l) % 256;
        e.go_cyc = timed ? t0 + 1 + 20 * (r * 4 + l) : -1;
        exp_q.push_back(e);
      end
    end
    fd_q.push_back(timed ? t0 + 641 : -1);
    frame_start = 1'b1;
    @(negedge clock);
    frame_start = 1'b0;
  endtask

  task automatic wait_frame(input int bound);
    int start;
    int n;
    start = fd_count;
    n = 0;
    while (fd_count == start && n < bound) begin
      @(negedge clock);
      n++;
    end
    if (fd_count == start) check("frame_done_timeout", 0, 1);
    repeat (5) @(negedge clock);
    check("busy_idle", int'(busy), 0);
  endtask

  localparam logic [11:0] COLS = {3'd4, 3'd2, 3'd1, 3'd6};

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    note_map    = '0;
    lane_colors = '0;
    hold_low    = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_go", int'(blk_go), 0);
    check("rst_x", int'(blk_x), 0);
    check("rst_y", int'(blk_y), 0);
    check("rst_color", int'(blk_color), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_done", int'(frame_done), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // empty grid: all erase draws, exact timing
    start_frame(32'h0, 12'h0, 1'b1);
    check("busy_load", int'(busy), 1);
    wait_frame(800);

    // two notes in row 0
    start_frame(32'h0000_0009, COLS, 1'b1);
    wait_frame(800);

    // inputs churn and a stray frame_start mid-frame: snapshot must hold
    begin
      int start;
      start_frame(32'hA5A5_0F0F, {3'd7, 3'd5, 3'd3, 3'd1}, 1'b1);
      @(negedge clock);
      start = fd_count;
      for (int i = 0; i < 800 && fd_count == start; i++) begin
        note_map    = (i % 2 == 0) ? 32'h5A5A_F0F0 : 32'hA5A5_0F0F;
        lane_colors = (i % 2 == 0) ? 12'hFFF : 12'h000;
        frame_start = (i == 100);
        @(negedge clock);
      end
      frame_start = 1'b0;
      if (fd_count == start) check("frame_done_timeout", 0, 1);
      repeat (60) @(negedge clock);
      check("no_extra_frame", int'(busy), 0);
    end

    // draw_block busy before first go
    hold_low = 1'b1;
    start_frame(32'h0000_0009, COLS, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      check("stall_go", int'(blk_go), 0);
      check("stall_x", int'(blk_x), 40);
    end
    check("stall_y", int'(blk_y), 16);
    check("stall_color", int'(blk_color), 6);
    hold_low = 1'b0;
    wait_frame(1000);

    // async reset while waiting for done to return high
    start_frame(32'h0000_0009, COLS, 1'b0);
    repeat (6) @(negedge clock);
    check("pre_rst_busy", int'(busy), 1);
    #1 reset = 1'b1;
    #1;
    check("arst_go", int'(blk_go), 0);
    check("arst_x", int'(blk_x), 0);
    check("arst_y", int'(blk_y), 0);
    check("arst_color", int'(blk_color), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_frame_done", int'(frame_done), 0);
    exp_q.delete();
    fd_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    start_frame(32'h8000_0001, COLS, 1'b1);
    wait_frame(800);

    check("exp_q_empty", exp_q.size(), 0);
    check("fd_q_empty", fd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
